// File: rtl/sd_cmd_framer_if.sv
// sd_cmd_framer_if: command request, byte-engine handshake and status bundle for sd_cmd_framer.
//   master: environment side; it issues Start/CmdIndex/CmdArg/CmdCRC and plays the SPI byte
//           engine (ByteDone, RxByte).
//   slave : framer side; it drives TxByte, SPI_Enable, CS_n, Busy, Done, TimedOut and R1.
interface sd_cmd_framer_if;
  logic        Start;
  logic [5:0]  CmdIndex;
  logic [31:0] CmdArg;
  logic [6:0]  CmdCRC;
  logic        ByteDone;
  logic [7:0]  RxByte;
  logic [7:0]  TxByte;
  logic        SPI_Enable;
  logic        CS_n;
  logic        Busy;
  logic        Done;
  logic        TimedOut;
  logic [7:0]  R1;

  modport master (
    output Start, CmdIndex, CmdArg, CmdCRC, ByteDone, RxByte,
    input  TxByte, SPI_Enable, CS_n, Busy, Done, TimedOut, R1
  );

  modport slave (
    input  Start, CmdIndex, CmdArg, CmdCRC, ByteDone, RxByte,
    output TxByte, SPI_Enable, CS_n, Busy, Done, TimedOut, R1
  );
endinterface

// File: rtl/sd_cmd_framer.sv
// sd_cmd_framer: frames one SD SPI-mode command (6 bytes) and polls for the R1 response.
// A command is PRE (one 0xFF byte, CS low), FRAME (6 bytes), RESP (0xFF polls until a byte
// with bit 7 clear or RESP_WAIT polls), POST (one 0xFF byte with CS high), then a Done pulse.
// Ports:
//   MasterCLK - system clock, rising edge
//   Reset     - synchronous active-high reset
//   bus       - sd_cmd_framer_if.slave: request fields, byte-engine handshake, status outputs
module sd_cmd_framer #(
  parameter int unsigned RESP_WAIT = 8
) (
  input logic           MasterCLK,
  input logic           Reset,
  sd_cmd_framer_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRE   = 3'd1;
  localparam logic [2:0] FRAME = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] POST  = 3'd4;

  localparam logic [7:0] RespWait = 8'(RESP_WAIT);

  logic [2:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  poll_q, poll_d;
  logic [5:0]  cmd_idx_q, cmd_idx_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic [6:0]  cmd_crc_q, cmd_crc_d;
  logic        done_q, done_d;
  logic        timed_out_q, timed_out_d;
  logic [7:0]  r1_q, r1_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    poll_d      = poll_q;
    cmd_idx_d   = cmd_idx_q;
    cmd_arg_d   = cmd_arg_q;
    cmd_crc_d   = cmd_crc_q;
    done_d      = 1'b0;
    timed_out_d = timed_out_q;
    r1_d        = r1_q;
    case (state_q)
      IDLE: begin
        // Start is only honoured here, so a Start while busy never touches the latched fields.
        if (bus.Start) begin
          state_d     = PRE;
          idx_d       = 3'd0;
          poll_d      = 8'd0;
          cmd_idx_d   = bus.CmdIndex;
          cmd_arg_d   = bus.CmdArg;
          cmd_crc_d   = bus.CmdCRC;
          timed_out_d = 1'b0;
          r1_d        = 8'hFF;
        end
      end
      PRE: begin
        if (bus.ByteDone) begin
          state_d = FRAME;
          idx_d   = 3'd0;
        end
      end
      FRAME: begin
        if (bus.ByteDone) begin
          if (idx_q == 3'd5) begin
            state_d = RESP;
            poll_d  = 8'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      RESP: begin
        if (bus.ByteDone) begin
          if (!bus.RxByte[7]) begin
            r1_d        = bus.RxByte;
            timed_out_d = 1'b0;
            state_d     = POST;
          end else begin
            poll_d = poll_q + 8'd1;
            // RESP_WAIT <= 255, so the counter stops here before it could wrap.
            if (poll_d == RespWait) begin
              r1_d        = 8'hFF;
              timed_out_d = 1'b1;
              state_d     = POST;
            end
          end
        end
      end
      POST: begin
        if (bus.ByteDone) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      poll_q      <= 8'd0;
      cmd_idx_q   <= 6'd0;
      cmd_arg_q   <= 32'd0;
      cmd_crc_q   <= 7'd0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      r1_q        <= 8'hFF;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      poll_q      <= poll_d;
      cmd_idx_q   <= cmd_idx_d;
      cmd_arg_q   <= cmd_arg_d;
      cmd_crc_q   <= cmd_crc_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      r1_q        <= r1_d;
    end
  end

  // TxByte is decoded from registered state only, so it moves the cycle after ByteDone and
  // holds steady between pulses.
  always_comb begin
    bus.TxByte = 8'hFF;
    if (state_q == FRAME) begin
      case (idx_q)
        3'd0:    bus.TxByte = {2'b01, cmd_idx_q};
        3'd1:    bus.TxByte = cmd_arg_q[31:24];
        3'd2:    bus.TxByte = cmd_arg_q[23:16];
        3'd3:    bus.TxByte = cmd_arg_q[15:8];
        3'd4:    bus.TxByte = cmd_arg_q[7:0];
        3'd5:    bus.TxByte = {cmd_crc_q, 1'b1};
        default: bus.TxByte = 8'hFF;
      endcase
    end
  end

  assign bus.CS_n       = !((state_q == PRE) || (state_q == FRAME) || (state_q == RESP));
  assign bus.SPI_Enable = (state_q != IDLE);
  assign bus.Busy       = (state_q != IDLE);
  assign bus.Done       = done_q;
  assign bus.TimedOut   = timed_out_q;
  assign bus.R1         = r1_q;

endmodule

// File: tb/tb_sd_cmd_framer.sv
module tb_sd_cmd_framer;
  localparam int unsigned RespWait = 8;

  logic MasterCLK = 1'b0;
  logic Reset;

  sd_cmd_framer_if bus();

  sd_cmd_framer #(.RESP_WAIT(RespWait)) dut (
    .MasterCLK (MasterCLK),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 MasterCLK = ~MasterCLK;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One ByteDone pulse; returns at the following falling edge.
  task automatic pulse_byte(input logic [7:0] rx);
    bus.ByteDone = 1'b1;
    bus.RxByte   = rx;
    @(negedge MasterCLK);
    bus.ByteDone = 1'b0;
    bus.Start    = 1'b0;
  endtask

  // Issues Start at the current falling edge, plays the byte engine, and returns at the falling
  // edge of the Done cycle. resp_at is the 1-based poll carrying the answer; outside
  // 1..RespWait the card never answers. inject pulses Start with other fields mid-frame.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                         input int resp_at, input logic [7:0] r1val, input bit inject);
    logic [7:0] exp_q[$];
    logic [7:0] rx;
    int         n;
    int         total;
    bit         to;
    to = !(resp_at >= 1 && resp_at <= int'(RespWait));
    n  = to ? int'(RespWait) : resp_at;
    exp_q.push_back(8'hFF);
    exp_q.push_back({2'b01, idx});
    exp_q.push_back(arg[31:24]);
    exp_q.push_back(arg[23:16]);
    exp_q.push_back(arg[15:8]);
    exp_q.push_back(arg[7:0]);
    exp_q.push_back({crc, 1'b1});
    for (int p = 0; p < n; p++) exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    total = exp_q.size();

    bus.CmdIndex = idx;
    bus.CmdArg   = arg;
    bus.CmdCRC   = crc;
    bus.Start    = 1'b1;
    @(negedge MasterCLK);
    bus.Start = 1'b0;
    check1("busy_on", bus.Busy, 1'b1);
    check1("cs_pre", bus.CS_n, 1'b0);
    check1("en_pre", bus.SPI_Enable, 1'b1);
    check1("done_low_start", bus.Done, 1'b0);

    for (int i = 0; i < total; i++) begin
      repeat ($urandom_range(0, 2)) begin
        check8("tx_stable", bus.TxByte, exp_q[i]);
        @(negedge MasterCLK);
      end
      check8("tx_byte", bus.TxByte, exp_q[i]);
      check1("cs_byte", bus.CS_n, (i == total - 1));
      check1("en_byte", bus.SPI_Enable, 1'b1);
      check1("done_mid", bus.Done, 1'b0);
      if (i >= 7 && i < 7 + n) begin
        if (!to && (i - 6) == resp_at) rx = r1val;
        else if (to) rx = 8'hFF;
        else rx = 8'($urandom) | 8'h80;
      end else begin
        rx = 8'($urandom);
      end
      if (inject && i == 3) begin
        bus.Start    = 1'b1;
        bus.CmdIndex = idx ^ 6'h2A;
        bus.CmdArg   = ~arg;
        bus.CmdCRC   = ~crc;
      end
      pulse_byte(rx);
    end

    check1("done_pulse", bus.Done, 1'b1);
    check1("busy_off", bus.Busy, 1'b0);
    check1("cs_done", bus.CS_n, 1'b1);
    check1("en_done", bus.SPI_Enable, 1'b0);
    check8("tx_idle", bus.TxByte, 8'hFF);
    check8("r1", bus.R1, to ? 8'hFF : r1val);
    check1("timedout", bus.TimedOut, to);
  endtask

  logic [31:0] arg_v;
  bit          b2b;

  initial begin
    Reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.CmdIndex = '0;
    bus.CmdArg   = '0;
    bus.CmdCRC   = '0;
    bus.ByteDone = 1'b0;
    bus.RxByte   = 8'hFF;
    repeat (2) @(negedge MasterCLK);
    check1("rst_cs", bus.CS_n, 1'b1);
    check1("rst_en", bus.SPI_Enable, 1'b0);
    check8("rst_tx", bus.TxByte, 8'hFF);
    check1("rst_busy", bus.Busy, 1'b0);
    check1("rst_done", bus.Done, 1'b0);
    check1("rst_to", bus.TimedOut, 1'b0);
    check8("rst_r1", bus.R1, 8'hFF);
    Reset = 1'b0;

    // ByteDone while idle is ignored.
    pulse_byte(8'h00);
    check1("idle_bd_busy", bus.Busy, 1'b0);
    check1("idle_bd_done", bus.Done, 1'b0);

    // CMD0: answer 0x01 on the first poll.
    run_cmd(6'd0, 32'h0, 7'h4A, 1, 8'h01, 1'b0);
    @(negedge MasterCLK);
    check1("done_one_cycle", bus.Done, 1'b0);

    // CMD17: answer 0x00 on the third poll.
    run_cmd(6'd17, 32'h12345678, 7'h2A, 3, 8'h00, 1'b0);
    @(negedge MasterCLK);

    // Card never answers.
    run_cmd(6'd8, 32'h000001AA, 7'h43, 0, 8'h00, 1'b0);
    @(negedge MasterCLK);
    check1("to_held", bus.TimedOut, 1'b1);

    // Start during FRAME is ignored; only one Done.
    run_cmd(6'd55, 32'hDEADBEEF, 7'h11, 2, 8'h05, 1'b1);
    repeat (3) begin
      @(negedge MasterCLK);
      check1("inject_no_done", bus.Done, 1'b0);
      check1("inject_idle", bus.Busy, 1'b0);
    end

    // Reset after the third FRAME ByteDone.
    arg_v        = 32'hA1B2C3D4;
    bus.CmdIndex = 6'd24;
    bus.CmdArg   = arg_v;
    bus.CmdCRC   = 7'h33;
    bus.Start    = 1'b1;
    @(negedge MasterCLK);
    bus.Start = 1'b0;
    repeat (4) pulse_byte(8'h00);
    check8("tx_before_rst", bus.TxByte, arg_v[15:8]);
    Reset = 1'b1;
    @(negedge MasterCLK);
    Reset = 1'b0;
    check1("abort_cs", bus.CS_n, 1'b1);
    check1("abort_en", bus.SPI_Enable, 1'b0);
    check1("abort_busy", bus.Busy, 1'b0);
    check1("abort_done", bus.Done, 1'b0);
    check8("abort_tx", bus.TxByte, 8'hFF);
    check8("abort_r1", bus.R1, 8'hFF);
    repeat (3) begin
      pulse_byte(8'h00);
      check1("abort_bd_done", bus.Done, 1'b0);
      check1("abort_bd_busy", bus.Busy, 1'b0);
    end

    // Reset and Start together: Reset wins.
    bus.Start = 1'b1;
    Reset     = 1'b1;
    @(negedge MasterCLK);
    bus.Start = 1'b0;
    Reset     = 1'b0;
    check1("rst_start_busy", bus.Busy, 1'b0);
    @(negedge MasterCLK);
    check1("rst_start_busy2", bus.Busy, 1'b0);

    run_cmd(6'd24, arg_v, 7'h33, 1, 8'h00, 1'b0);

    // Randomized commands, some issued back-to-back in the Done cycle.
    for (int k = 0; k < 8; k++) begin
      b2b = ($urandom_range(0, 1) == 1);
      if (!b2b) @(negedge MasterCLK);
      run_cmd(6'($urandom), $urandom, 7'($urandom), $urandom_range(1, 10),
              8'($urandom_range(0, 127)), ($urandom_range(0, 3) == 0));
    end
    @(negedge MasterCLK);
    check1("final_done_low", bus.Done, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sd_cmd_framer.md
SD_CMD_FRAMER -- requirements
Module: sd_cmd_framer

Interface
REQ-001 SHALL provide parameter RESP_WAIT, default 8, the maximum number of response-poll bytes before timeout (legal range 1..255).
REQ-002 SHALL provide ports MasterCLK in 1, the system clock; all logic is clocked on its rising edge.
REQ-003 SHALL provide Reset in 1, a synchronous active-high reset.
REQ-004 SHALL provide Start in 1, a request pulse that is sampled every cycle.
REQ-005 SHALL provide CmdIndex in 6, the SD command number.
REQ-006 SHALL provide CmdArg in 32, the command argument.
REQ-007 SHALL provide CmdCRC in 7, the CRC7 of the frame.
REQ-008 SHALL provide ByteDone in 1, a single-cycle pulse from the SPI byte engine marking a completed 8-bit exchange.
REQ-009 SHALL provide RxByte in 8, the byte received from MISO; it is valid in the ByteDone cycle.
REQ-010 SHALL provide TxByte out 8, the byte for the engine to shift out MSB first.
REQ-011 SHALL provide SPI_Enable out 1, which gates the SPI clock and MOSI in the byte engine.
REQ-012 SHALL provide CS_n out 1, the active-low card select.
REQ-013 SHALL provide Busy out 1, high from Start acceptance until Done.
REQ-014 SHALL provide Done out 1, a one-cycle completion pulse.
REQ-015 SHALL provide TimedOut out 1, valid with Done and held until the next accepted Start.
REQ-016 SHALL provide R1 out 8, the response byte, held until the next accepted Start.

Function
REQ-017 FSM states SHALL be IDLE, PRE, FRAME, RESP, POST, each listed below with its outputs.
- IDLE: SPI_Enable=0, CS_n=1, TxByte=0xFF.
- PRE: one 0xFF byte with CS_n=0.
- FRAME: 6 bytes with CS_n=0.
- RESP: 0xFF poll bytes with CS_n=0.
- POST: one 0xFF byte with CS_n=1.
REQ-018 Start in IDLE SHALL be accepted and the machine SHALL enter PRE next cycle; CmdIndex/CmdArg/CmdCRC are latched that cycle, and Busy=1 from the following cycle.
REQ-019 Start while Busy=1 SHALL be ignored, with no effect on latched fields or state.
REQ-020 ByteDone in IDLE SHALL be ignored.
REQ-021 State and byte-index advance SHALL occur only on a cycle with ByteDone=1.
- TxByte updates the cycle after ByteDone.
- TxByte is stable between ByteDone pulses.
REQ-022 FRAME byte order SHALL be, for index k=0..5:
- k=0: {2'b01, CmdIndex}.
- k=1..4: CmdArg[31:24], [23:16], [15:8], [7:0].
- k=5: {CmdCRC, 1'b1}.
REQ-023 After the 6th ByteDone in FRAME, the machine SHALL enter RESP with poll counter = 0.
REQ-024 In RESP, on ByteDone with RxByte[7]=0: R1<=RxByte, TimedOut<=0, next state POST.
REQ-025 In RESP, on ByteDone with RxByte[7]=1: the poll counter SHALL increment.
- The byte that makes the counter equal RESP_WAIT sets R1<=0xFF and TimedOut<=1, next state POST.
- The counter is 8 bits wide and never wraps within a command.
REQ-026 In POST, on ByteDone the machine SHALL return to IDLE.
- Done=1 for exactly that one next cycle; Busy=0 in the same cycle.
- Start is acceptable again in that Done cycle.
REQ-027 SPI_Enable SHALL be 1 in PRE, FRAME, RESP and POST, and 0 in IDLE.
REQ-028 Command latency SHALL be exactly 8+n byte exchanges (PRE 1 + FRAME 6 + n RESP + POST 1), where 1<=n<=RESP_WAIT.

Reset
REQ-029 When Reset=1 at a clock edge, the next-cycle outputs SHALL be: state=IDLE, CS_n=1, SPI_Enable=0, TxByte=0xFF, Busy=0, Done=0, TimedOut=0, R1=0xFF, and all counters 0.
REQ-030 Reset mid-command SHALL abort immediately with no Done pulse; a subsequent ByteDone is ignored.
REQ-031 Reset and Start in the same cycle: Reset SHALL win and Start is discarded.

Verification
REQ-032 CMD0 scenario: CmdIndex=0, Arg=0, CRC=0x4A, card answers 0x01 on the 1st poll.
- TxByte sequence: FF,40,00,00,00,00,95,FF(poll),FF(post).
- R1=0x01, TimedOut=0, Done after the 9th ByteDone.
REQ-033 CMD17 scenario: Arg=0x12345678, answer 0x00 on the 3rd poll.
- Frame bytes: 51,12,34,56,78,{CRC,1}.
- Exactly 3 poll bytes, R1=0x00.
REQ-034 Timeout scenario: RxByte held at 0xFF throughout.
- Exactly 8 poll bytes are sent.
- Done with TimedOut=1 and R1=0xFF after the 16th ByteDone.
REQ-035 Start pulsed during FRAME with a different CmdIndex -> frame bytes unchanged, and only one Done occurs.
REQ-036 Reset asserted after the 3rd FRAME ByteDone -> next cycle CS_n=1, SPI_Enable=0, Busy=0, and no Done.
- A fresh Start then produces a full, correct frame.
REQ-037 Back-to-back scenario: Start is asserted in the Done cycle -> accepted.
- CS_n is 1 for at least one cycle between commands.
